// File: rtl/afe2256_cfg_pkg.sv
// Register map, FSM state types and the fixed power-up table for the AFE2256 configuration sequencer.
package afe2256_cfg_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned WORD_W    = ADDR_W + DATA_W;
  localparam int unsigned TABLE_LEN = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned TP_W      = 5;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TABLE_LEN - 1);

  localparam logic [ADDR_W-1:0] REG_RESET        = 8'h00;
  localparam logic [ADDR_W-1:0] REG_TEST_PATTERN = 8'h10;
  localparam logic [ADDR_W-1:0] REG_STR          = 8'h11;
  localparam logic [ADDR_W-1:0] REG_POWER_DOWN   = 8'h13;
  localparam logic [ADDR_W-1:0] REG_TRIM_LOAD    = 8'h30;
  localparam logic [ADDR_W-1:0] REG_INPUT_RANGE  = 8'h5C;
  localparam logic [ADDR_W-1:0] REG_POWER_MODE   = 8'h5D;
  localparam logic [ADDR_W-1:0] REG_INTG_MODE    = 8'h5E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XFER,
    ST_GAP,
    ST_SYNC,
    ST_DONE
  } cfg_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_SHIFT,
    TX_HOLD
  } tx_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cfg_word_t;

  // Init table entry; only the test-pattern word depends on the latched tp_sel.
  function automatic cfg_word_t init_word(input logic [IDX_W-1:0] idx,
                                          input logic [TP_W-1:0]  tp_sel);
    cfg_word_t w;
    w.addr = REG_RESET;
    w.data = 16'h0000;
    case (idx)
      3'd0: begin w.addr = REG_RESET;        w.data = 16'h0001;                 end
      3'd1: begin w.addr = REG_TRIM_LOAD;    w.data = 16'h0002;                 end
      3'd2: begin w.addr = REG_POWER_DOWN;   w.data = 16'h0000;                 end
      3'd3: begin w.addr = REG_TEST_PATTERN; w.data = {6'b0, tp_sel, 5'b0};     end
      3'd4: begin w.addr = REG_STR;          w.data = 16'h0010;                 end
      3'd5: begin w.addr = REG_INPUT_RANGE;  w.data = 16'h0000;                 end
      3'd6: begin w.addr = REG_POWER_MODE;   w.data = 16'h0000;                 end
      3'd7: begin w.addr = REG_INTG_MODE;    w.data = 16'h0000;                 end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/afe_spi_word_tx.sv
// 24-bit SPI word transmitter: chip-select setup, MSB-first shift with divided SCK, chip-select hold.
module afe_spi_word_tx
  import afe2256_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic              sck,
  output logic              sdi,
  output logic              sen_n,
  output logic              word_done_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(WORD_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  tx_state_t         state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic              sck_nxt, sdi_nxt, sen_n_nxt;
  logic              div_end;

  assign div_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sck     <= 1'b0;
      sdi     <= 1'b0;
      sen_n   <= 1'b1;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      sck     <= sck_nxt;
      sdi     <= sdi_nxt;
      sen_n   <= sen_n_nxt;
    end
  end

  // SCK low half precedes high half, so sdi always settles a full half-period before the rising edge.
  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    sck_nxt     = sck;
    sdi_nxt     = sdi;
    sen_n_nxt   = sen_n;
    word_done_c = 1'b0;
    case (state)
      TX_IDLE: begin
        if (load) begin
          state_nxt   = TX_SETUP;
          div_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          shreg_nxt   = word;
          sdi_nxt     = word[WORD_W-1];
          sck_nxt     = 1'b0;
          sen_n_nxt   = 1'b0;
        end
      end
      TX_SETUP: begin
        div_cnt_nxt = div_cnt + DIV_W'(1);
        if (div_end) begin
          div_cnt_nxt = '0;
          state_nxt   = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        div_cnt_nxt = div_cnt + DIV_W'(1);
        if (div_end) begin
          div_cnt_nxt = '0;
          if (!sck) begin
            sck_nxt = 1'b1;
          end else begin
            sck_nxt     = 1'b0;
            shreg_nxt   = {shreg[WORD_W-2:0], 1'b0};
            sdi_nxt     = shreg[WORD_W-2];
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              state_nxt = TX_HOLD;
              sdi_nxt   = 1'b0;
            end
          end
        end
      end
      TX_HOLD: begin
        div_cnt_nxt = div_cnt + DIV_W'(1);
        if (div_end) begin
          div_cnt_nxt = '0;
          sen_n_nxt   = 1'b1;
          state_nxt   = TX_IDLE;
          word_done_c = 1'b1;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/afe2256_cfg_sequencer.sv
// AFE2256 power-up configuration sequencer and host register-write port driving the ROIC SPI pins.
// Optional frame-sync pulse after the init table is enabled with `define AFE_CFG_SYNC_EN.
module afe2256_cfg_sequencer
  import afe2256_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8,
  parameter int unsigned SYNC_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TP_W-1:0]   tp_sel,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  cmd_idx,
  output logic              roic_spi_sck,
  output logic              roic_spi_sdi,
  output logic              roic_spi_sen_n,
  output logic              roic_sync
);

  localparam int unsigned CNT_MAX = (GAP_CYCLES > SYNC_WIDTH) ? GAP_CYCLES : SYNC_WIDTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  // The LOAD cycle is already a chip-select-high cycle, so GAP itself is one shorter.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
`ifdef AFE_CFG_SYNC_EN
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'((SYNC_WIDTH > 0) ? SYNC_WIDTH - 1 : 0);
`endif

  cfg_state_t       state, state_nxt;
  logic             table_mode;
  logic [TP_W-1:0]  tp_lat;
  cfg_word_t        host_word;
  logic [CNT_W-1:0] cnt;
  cfg_word_t        tx_word_c;
  logic             tx_load_c;
  logic             tx_done_c;

  assign tx_load_c = (state == ST_LOAD);
  assign tx_word_c = table_mode ? init_word(cmd_idx, tp_lat) : host_word;

  afe_spi_word_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (tx_load_c),
    .word        (tx_word_c),
    .sck         (roic_spi_sck),
    .sdi         (roic_spi_sdi),
    .sen_n       (roic_spi_sen_n),
    .word_done_c (tx_done_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // start wins over wr_req; the host request stays pending until the FSM is back in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start || wr_req) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_XFER;
      ST_XFER: if (tx_done_c) state_nxt = ST_GAP;
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          if (!table_mode) begin
            state_nxt = ST_IDLE;
          end else if (cmd_idx != IDX_LAST) begin
            state_nxt = ST_LOAD;
          end else begin
`ifdef AFE_CFG_SYNC_EN
            state_nxt = ST_SYNC;
`else
            state_nxt = ST_DONE;
`endif
          end
        end
      end
`ifdef AFE_CFG_SYNC_EN
      ST_SYNC: if (cnt == SYNC_LAST) state_nxt = ST_DONE;
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_mode <= 1'b0;
      tp_lat     <= '0;
      host_word  <= '0;
      cmd_idx    <= '0;
      cnt        <= '0;
      wr_ack     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      busy   <= (state_nxt != ST_IDLE);
      done   <= (state == ST_DONE);
      if (state == ST_IDLE) begin
        if (start) begin
          tp_lat     <= tp_sel;
          cmd_idx    <= '0;
          table_mode <= 1'b1;
        end else if (wr_req) begin
          host_word  <= '{addr: wr_addr, data: wr_data};
          table_mode <= 1'b0;
          wr_ack     <= 1'b1;
        end
      end
      if (state == ST_GAP && state_nxt == ST_LOAD) cmd_idx <= cmd_idx + IDX_W'(1);
      if (state_nxt != state)                        cnt <= '0;
      else if (state == ST_GAP || state == ST_SYNC)  cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef AFE_CFG_SYNC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) roic_sync <= 1'b0;
    else        roic_sync <= (state == ST_SYNC);
  end
`else
  assign roic_sync = 1'b0;
`endif

endmodule

// File: tb/tb_afe2256_cfg_sequencer.sv
// Bench for afe2256_cfg_sequencer: SPI pin decoder compared against an expected-word queue.
`timescale 1ns/1ps
module tb_afe2256_cfg_sequencer;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_CYCLES = 8;
  localparam int unsigned SYNC_WIDTH = 4;
  localparam int          WIN_LEN    = 50 * CLK_DIV;

  typedef struct {
    logic [23:0] word;
    bit          chk_gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  tp_sel = '0;
  logic        wr_req = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack, busy, done;
  logic [2:0]  cmd_idx;
  logic        sck, sdi, sen_n, roic_sync;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   windows = 0;
  int   sync_samples = 0;

  afe2256_cfg_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .SYNC_WIDTH (SYNC_WIDTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .tp_sel         (tp_sel),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .busy           (busy),
    .done           (done),
    .cmd_idx        (cmd_idx),
    .roic_spi_sck   (sck),
    .roic_spi_sdi   (sdi),
    .roic_spi_sen_n (sen_n),
    .roic_sync      (roic_sync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  function automatic logic [23:0] model_word(input int idx, input logic [4:0] tp);
    logic [23:0] w;
    case (idx)
      0:       w = 24'h000001;
      1:       w = 24'h300002;
      2:       w = 24'h130000;
      3:       w = {8'h10, 6'b0, tp, 5'b0};
      4:       w = 24'h110010;
      5:       w = 24'h5C0000;
      6:       w = 24'h5D0000;
      default: w = 24'h5E0000;
    endcase
    return w;
  endfunction

  task automatic push_word(input logic [23:0] w, input bit chk_gap);
    exp_t e;
    e.word    = w;
    e.chk_gap = chk_gap;
    sb.push_back(e);
  endtask

  task automatic push_table(input logic [4:0] tp);
    for (int i = 0; i < 8; i++) push_word(model_word(i, tp), i != 0);
  endtask

  task automatic pulse_start(input logic [4:0] tp);
    tp_sel = tp;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    tp_sel = '0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(done_cnt >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  // SPI pin decoder: rebuilds each word from sdi at sck rising edges and times every window.
  initial begin
    logic        prev_sck, prev_sen, prev_sdi;
    logic [23:0] shreg;
    int          rises, low_cnt, high_cnt;
`ifdef AFE_CFG_SYNC_EN
    logic        prev_sync;
    int          last_rise_cyc, sync_len;
    prev_sync = 1'b0; last_rise_cyc = 0; sync_len = 0;
`endif
    prev_sck = 1'b0; prev_sen = 1'b1; prev_sdi = 1'b0;
    shreg = '0; rises = 0; low_cnt = 0; high_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sck = 1'b0; prev_sen = 1'b1; prev_sdi = 1'b0;
        shreg = '0; rises = 0; low_cnt = 0; high_cnt = 0;
      end else begin
        if (done) done_cnt++;
        if (roic_sync) sync_samples++;
        if (!prev_sen && sen_n) begin
          windows++;
          check("sck_rises", 32'(rises), 24);
          check("sen_low_len", 32'(low_cnt), 32'(WIN_LEN));
          check("sb_pending", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) check("spi_word", 32'(shreg), 32'(sb.pop_front().word));
          high_cnt = 0;
`ifdef AFE_CFG_SYNC_EN
          last_rise_cyc = cyc;
`endif
        end
        if (prev_sen && !sen_n) begin
          if (sb.size() != 0 && sb[0].chk_gap) check("gap_len", 32'(high_cnt), GAP_CYCLES);
          rises = 0; low_cnt = 0; shreg = '0;
        end
        if (!sen_n) begin
          low_cnt++;
          if (sck && !prev_sck) begin
            check("sdi_setup", 32'(sdi), 32'(prev_sdi));
            shreg = {shreg[22:0], sdi};
            rises++;
          end else if (sck && prev_sck) begin
            check("sdi_hold", 32'(sdi), 32'(prev_sdi));
          end
        end else begin
          high_cnt++;
        end
`ifdef AFE_CFG_SYNC_EN
        if (roic_sync && !prev_sync) begin
          check("sync_start", 32'(cyc - last_rise_cyc), GAP_CYCLES);
          sync_len = 0;
        end
        if (roic_sync) sync_len++;
        if (!roic_sync && prev_sync) begin
          check("sync_width", 32'(sync_len), SYNC_WIDTH);
          check("done_after_sync", 32'(done), 1);
        end
        prev_sync = roic_sync;
`endif
        prev_sck = sck;
        prev_sen = sen_n;
        prev_sdi = sdi;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int n;

    repeat (3) @(negedge clk);
    check("rst_sen_n", 32'(sen_n), 1);
    check("rst_sck", 32'(sck), 0);
    check("rst_sdi", 32'(sdi), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wr_ack", 32'(wr_ack), 0);
    check("rst_cmd_idx", 32'(cmd_idx), 0);
    check("rst_sync", 32'(roic_sync), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Full table with tp_sel=13; tp_sel is cleared right after start to prove it was latched.
    w0 = windows;
    push_table(5'h13);
    pulse_start(5'h13);
    check("t1_busy", 32'(busy), 1);
    check("t1_sen_lat1", 32'(sen_n), 1);
    @(negedge clk);
    check("t1_sen_lat2", 32'(sen_n), 0);
    check("t1_idx0", 32'(cmd_idx), 0);
    wait_done(1, 3000);
    wait_idle(50);
    repeat (20) @(negedge clk);
    check("t1_windows", 32'(windows - w0), 8);
    check("t1_sb_empty", 32'(sb.size()), 0);
    check("t1_done_once", 32'(done_cnt), 1);

    // Single host write from IDLE.
    w0 = windows;
    push_word(24'h5CA5F0, 1'b0);
    wr_addr = 8'h5C; wr_data = 16'hA5F0; wr_req = 1'b1;
    @(negedge clk);
    check("t3_wr_ack", 32'(wr_ack), 1);
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    @(negedge clk);
    check("t3_ack_pulse", 32'(wr_ack), 0);
    wait_idle(400);
    repeat (20) @(negedge clk);
    check("t3_windows", 32'(windows - w0), 1);
    check("t3_sb_empty", 32'(sb.size()), 0);
    check("t3_no_done", 32'(done_cnt), 1);

    // start and wr_req together: table first, host word after done, extra start ignored.
    w0 = windows;
    push_table(5'h05);
    push_word(24'h5CA5F0, 1'b0);
    wr_addr = 8'h5C; wr_data = 16'hA5F0; wr_req = 1'b1;
    pulse_start(5'h05);
    check("t4_no_ack", 32'(wr_ack), 0);
    check("t4_busy", 32'(busy), 1);
    repeat (300) @(negedge clk);
    pulse_start(5'h1F);
    n = 0;
    while (!wr_ack && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("t4_ack_seen", 32'(wr_ack), 1);
    check("t4_done_before_ack", 32'(done_cnt), 2);
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    @(negedge clk);
    wait_idle(400);
    repeat (20) @(negedge clk);
    check("t4_windows", 32'(windows - w0), 9);
    check("t4_sb_empty", 32'(sb.size()), 0);
    check("t4_done_cnt", 32'(done_cnt), 2);

    // Asynchronous reset while word 3 is shifting, then a clean restart from word 0.
    w0 = windows;
    push_table(5'h0A);
    pulse_start(5'h0A);
    n = 0;
    while (!(cmd_idx == 3'd3 && sck) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_word3", 32'(cmd_idx), 3);
    check("t5_shifting", 32'(sck), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_sen_n_async", 32'(sen_n), 1);
    check("t5_sck_async", 32'(sck), 0);
    check("t5_busy_async", 32'(busy), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    check("t5_words_before_rst", 32'(windows - w0), 3);
    check("t5_no_done", 32'(done_cnt), 2);
    @(negedge clk);
    w0 = windows;
    push_table(5'h0A);
    pulse_start(5'h0A);
    wait_done(3, 3000);
    wait_idle(50);
    repeat (20) @(negedge clk);
    check("t5_windows", 32'(windows - w0), 8);
    check("t5_sb_empty", 32'(sb.size()), 0);
    check("t5_done_cnt", 32'(done_cnt), 3);

`ifdef AFE_CFG_SYNC_EN
    check("sync_samples", 32'(sync_samples), 3 * SYNC_WIDTH);
`else
    check("sync_tied_low", 32'(sync_samples), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
